// File: rtl/mio_bus_mc_pkg.sv
// Shared constants for the mio_bus_mc memory-mapped I/O bus: local register
// map, CTRL/STATUS bit positions and the default slot map.
package mio_bus_mc_pkg;

  // Local window byte offsets
  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_PERIOD   = 6'h04;
  localparam logic [5:0] OFF_COUNT    = 6'h08;
  localparam logic [5:0] OFF_STATUS   = 6'h0C;
  localparam logic [5:0] OFF_SCRATCH0 = 6'h10;
  localparam logic [5:0] OFF_ERRADDR  = 6'h3C;

  // Word indices (mem_a[5:2]) of the same registers
  localparam logic [3:0] W_CTRL     = OFF_CTRL[5:2];
  localparam logic [3:0] W_PERIOD   = OFF_PERIOD[5:2];
  localparam logic [3:0] W_COUNT    = OFF_COUNT[5:2];
  localparam logic [3:0] W_STATUS   = OFF_STATUS[5:2];
  localparam logic [3:0] W_SCRATCH0 = OFF_SCRATCH0[5:2];
  localparam logic [3:0] W_ERRADDR  = OFF_ERRADDR[5:2];

  // CTRL bits
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_IE      = 1;
  localparam int unsigned CTRL_ONESHOT = 2;
  localparam int unsigned CTRL_EIE     = 3;

  // STATUS bits
  localparam int unsigned STAT_TICK = 0;
  localparam int unsigned STAT_ERR  = 1;

  // Default slot map and local window
  localparam logic [31:0] DEF_SLOT_BASE    = 32'h0000_0000;
  localparam logic [31:0] DEF_SLOT_MASK    = 32'hFFFF_F800;
  localparam logic [31:0] DEF_LOCAL_BASE   = 32'h0000_1000;
  localparam logic [31:0] DEF_TIMER_PERIOD = 32'd4_000_000;

  // Source of the CPU read data
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_SLOT  = 2'd1,
    SRC_LOCAL = 2'd2
  } rd_src_e;

endpackage

// File: rtl/mio_bus_mc_timer.sv
// Programmable interval timer: free-running COUNT that wraps at PERIOD and
// emits a one-cycle tick; requests EN clear after a tick in oneshot mode.
module mio_timer
  import mio_bus_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [31:0] period_i,
  input  logic        period_wr_i,
  input  logic        oneshot_i,
  output logic [31:0] count_o,
  output logic        tick_o,
  output logic        en_clr_o
);

  logic [31:0] count_q, count_d;
  logic        running;

  // Tick when the count reaches PERIOD; a PERIOD write restarts from zero
  always_comb begin
    running  = enable_i && (period_i != '0);
    tick_o   = running && !period_wr_i && (count_q == period_i);
    en_clr_o = tick_o && oneshot_i;
    count_d  = count_q;
    if (period_wr_i) begin
      count_d = '0;
    end else if (tick_o) begin
      count_d = '0;
    end else if (running) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mio_bus_mc.sv
// mio_bus_mc: CPU data-port address decoder for NSLOT external slots plus a
// local register window (timer, W1C status, scratch, error address).
// Optional bus-error capture is enabled by defining MIO_BUS_MC_BUSERR_EN.
module mio_bus_mc
  import mio_bus_mc_pkg::*;
#(
  parameter int unsigned            NSLOT            = 6,
  parameter logic [NSLOT*32-1:0]    SLOT_BASE        = {NSLOT{DEF_SLOT_BASE}},
  parameter logic [NSLOT*32-1:0]    SLOT_MASK        = {NSLOT{DEF_SLOT_MASK}},
  parameter logic [31:0]            LOCAL_BASE       = DEF_LOCAL_BASE,
  parameter int unsigned            NSCRATCH         = 4,
  parameter logic [31:0]            TIMER_PERIOD_RST = DEF_TIMER_PERIOD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           mem_a,
  input  logic [31:0]           d_t_mem,
  output logic [31:0]           d_f_mem,
  input  logic                  wmem,
  input  logic                  rmem,
  output logic [NSLOT-1:0]      slot_sel,
  output logic [NSLOT-1:0]      slot_we,
  output logic [NSLOT-1:0]      slot_re,
  output logic [31:0]           slot_a,
  output logic [31:0]           slot_wd,
  input  logic [NSLOT*32-1:0]   slot_rd,
  output logic                  irq
);

  logic             local_hit;
  logic             slot_any;
  logic [NSLOT-1:0] slot_hit;
  logic [3:0]       widx;
  logic             wr_local;
  logic             period_wr;
  rd_src_e          rd_src;

  logic [3:0]  ctrl_q,    ctrl_d;
  logic [31:0] period_q,  period_d;
  logic [1:0]  status_q,  status_d;
  logic [31:0] scratch_q [NSCRATCH];
  logic [31:0] scratch_d [NSCRATCH];

  logic [31:0] count;
  logic        tmr_tick;
  logic        tmr_en_clr;
  logic        err_set;
  logic [31:0] erraddr;

  assign local_hit = (mem_a[31:6] == LOCAL_BASE[31:6]);
  assign widx      = mem_a[5:2];
  assign wr_local  = wmem && local_hit;
  assign period_wr = wr_local && (widx == W_PERIOD);

  // Slot decode: lowest matching index wins, local window masks all slots
  always_comb begin
    slot_hit = '0;
    slot_any = 1'b0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (!slot_any &&
          ((mem_a & SLOT_MASK[32*i +: 32]) ==
           (SLOT_BASE[32*i +: 32] & SLOT_MASK[32*i +: 32]))) begin
        slot_hit[i] = 1'b1;
        slot_any    = 1'b1;
      end
    end
    if (local_hit) begin
      slot_hit = '0;
      slot_any = 1'b0;
    end
  end

  assign slot_sel = slot_hit;
  assign slot_we  = slot_hit & {NSLOT{wmem}};
  assign slot_re  = slot_hit & {NSLOT{rmem}};
  assign slot_a   = mem_a;
  assign slot_wd  = d_t_mem;

  mio_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (ctrl_q[CTRL_EN]),
    .period_i    (period_q),
    .period_wr_i (period_wr),
    .oneshot_i   (ctrl_q[CTRL_ONESHOT]),
    .count_o     (count),
    .tick_o      (tmr_tick),
    .en_clr_o    (tmr_en_clr)
  );

`ifdef MIO_BUS_MC_BUSERR_EN
  logic [31:0] erraddr_q;

  assign err_set = (wmem || rmem) && !local_hit && !slot_any;

  // First-error-wins capture of the faulting address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erraddr_q <= '0;
    end else if (err_set && !status_q[STAT_ERR]) begin
      erraddr_q <= mem_a;
    end
  end

  assign erraddr = erraddr_q;
`else
  assign err_set = 1'b0;
  assign erraddr = '0;
`endif

  // Register file next state; CPU CTRL write is applied after the oneshot
  // clear and hardware status sets after W1C so that those sides win.
  always_comb begin
    ctrl_d    = ctrl_q;
    period_d  = period_q;
    status_d  = status_q;
    scratch_d = scratch_q;
    if (tmr_en_clr) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end
    if (wr_local) begin
      case (widx)
        W_CTRL:   ctrl_d   = d_t_mem[3:0];
        W_PERIOD: period_d = d_t_mem;
        W_STATUS: status_d = status_q & ~d_t_mem[1:0];
        default: begin
          for (int unsigned k = 0; k < NSCRATCH; k++) begin
            if (widx == 4'(k + 32'(W_SCRATCH0))) begin
              scratch_d[k] = d_t_mem;
            end
          end
        end
      endcase
    end
    if (tmr_tick) begin
      status_d[STAT_TICK] = 1'b1;
    end
    if (err_set) begin
      status_d[STAT_ERR] = 1'b1;
    end
  end

  // Register file state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      period_q  <= TIMER_PERIOD_RST;
      status_q  <= '0;
      scratch_q <= '{default: '0};
    end else begin
      ctrl_q    <= ctrl_d;
      period_q  <= period_d;
      status_q  <= status_d;
      scratch_q <= scratch_d;
    end
  end

  // Read mux: local registers, selected slot (one-hot AND-OR) or zero
  always_comb begin
    if (local_hit) begin
      rd_src = SRC_LOCAL;
    end else if (slot_any) begin
      rd_src = SRC_SLOT;
    end else begin
      rd_src = SRC_NONE;
    end
    d_f_mem = '0;
    case (rd_src)
      SRC_SLOT: begin
        for (int unsigned i = 0; i < NSLOT; i++) begin
          if (slot_hit[i]) begin
            d_f_mem = d_f_mem | slot_rd[32*i +: 32];
          end
        end
      end
      SRC_LOCAL: begin
        case (widx)
          W_CTRL:    d_f_mem = {28'h0, ctrl_q};
          W_PERIOD:  d_f_mem = period_q;
          W_COUNT:   d_f_mem = count;
          W_STATUS:  d_f_mem = {30'h0, status_q};
          W_ERRADDR: d_f_mem = erraddr;
          default: begin
            for (int unsigned k = 0; k < NSCRATCH; k++) begin
              if (widx == 4'(k + 32'(W_SCRATCH0))) begin
                d_f_mem = scratch_q[k];
              end
            end
          end
        endcase
      end
      default: d_f_mem = '0;
    endcase
  end

  assign irq = (status_q[STAT_TICK] & ctrl_q[CTRL_IE]) |
               (status_q[STAT_ERR]  & ctrl_q[CTRL_EIE]);

endmodule

// File: doc/mio_bus_mc.md
Name: mio_bus_mc

Overview:
- Second-generation memory-mapped I/O bus for the CPU data port.
- Decodes `mem_a` into NSLOT external peripheral channels. Each channel is set by a base/mask parameter pair; VRAM, key I/O, segment, ROM and RAM are typical clients.
- Hosts a local register window containing a programmable interval timer, a W1C status/interrupt register and NSCRATCH scratch registers (cursor row/column, key-F0 flags and similar).
- Drives a single level interrupt to the CPU.

Parameters:
- NSLOT, 6, number of external slave channels (1..16).
- SLOT_BASE, {NSLOT{32'h0}}, flat NSLOT*32 vector; slot i base is bits [32i+31:32i].
- SLOT_MASK, {NSLOT{32'hFFFF_F800}}, flat NSLOT*32 vector. Slot i hits when (mem_a & mask_i) == (base_i & mask_i).
- LOCAL_BASE, 32'h0000_1000, 64-byte aligned base of the local window.
- NSCRATCH, 4, scratch registers (1..10).
- TIMER_PERIOD_RST, 32'd4_000_000, PERIOD reset value (25 Hz at 100 MHz).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_a  in  32  CPU byte address.
- d_t_mem  in  32  CPU write data.
- d_f_mem  out  32  CPU read data.
- wmem  in  1  write strobe.
- rmem  in  1  read strobe.
- slot_sel  out  NSLOT  one-hot select; zero when no slot hits.
- slot_we  out  NSLOT  wmem qualified per slot.
- slot_re  out  NSLOT  rmem qualified per slot.
- slot_a  out  32  mem_a passthrough.
- slot_wd  out  32  d_t_mem passthrough.
- slot_rd  in  NSLOT*32  per-slot read data, flat vector.
- irq  out  1  level interrupt, active high.

Behaviour:
- Decode
  - Local window hit: mem_a[31:6] == LOCAL_BASE[31:6]. The local window takes priority over all slots.
  - Slot priority: lowest index wins on overlap. slot_sel is strictly one-hot or zero.
  - Decode and the read mux are purely combinational; read latency is 0 cycles.
  - d_f_mem selects the selected slot's slot_rd, or local register data. An unmapped address returns 32'h0.
- Local registers
  - Word offset is mem_a[5:2]; byte bits [1:0] are ignored. Writes take effect on the posedge where wmem=1.
  - 0x00 CTRL, RW, reset 0:
    - bit0 EN: timer enable.
    - bit1 IE: tick interrupt enable.
    - bit2 ONESHOT: clear EN after the first tick.
    - bit3 EIE: error interrupt enable.
    - Other bits read as 0.
  - 0x04 PERIOD, RW, reset TIMER_PERIOD_RST. A write to PERIOD also zeroes COUNT on the same edge.
  - 0x08 COUNT, read-only; writes are ignored. Reset 0.
  - 0x0C STATUS, reset 0.
    - bit0 TICK, sticky.
    - bit1 ERR, sticky.
    - Writing 1 to a bit clears it; writing 0 has no effect.
  - 0x10 + 4k SCRATCH[k], k < NSCRATCH, RW, reset 0.
  - 0x3C ERRADDR, read-only; see Optional Feature.
  - Unused offsets read 0 and ignore writes.
- Timer
  - With EN=1 and PERIOD≠0: if COUNT == PERIOD, then COUNT←0, TICK←1, and EN←0 when ONESHOT=1. Otherwise COUNT←COUNT+1.
  - The tick fires every PERIOD+1 cycles.
  - PERIOD==0 halts the counter; COUNT holds its value.
  - EN=0: COUNT holds.
  - A tick and a W1C clear of TICK on the same edge: the set wins and TICK stays 1.
  - CTRL written with EN=1 in the same cycle that ONESHOT would clear EN: the CPU write wins.
- irq = (TICK & IE) | (ERR & EIE). It is combinational from registers, with no glitch path from mem_a.
- Reset asserted mid-operation forces all registers to their reset values immediately. irq deasserts asynchronously.

Optional Feature:
- Macro: MIO_BUS_MC_BUSERR_EN.
- Defined:
  - A wmem or rmem strobe to an address hitting neither a slot nor the local window sets STATUS.ERR.
  - The same event latches mem_a into ERRADDR, first-error-wins: ERRADDR only loads while ERR=0.
  - ERRADDR reset value is 0.
- Undefined:
  - ERR stays 0 and ERRADDR reads 0; EIE is writable but has no effect.
  - No decode-error logic is synthesised.

Decomposition:
- Package mio_bus_mc_pkg:
  - Local register offsets: CTRL=0x0, PERIOD=0x4, COUNT=0x8, STATUS=0xC, SCRATCH0=0x10, ERRADDR=0x3C.
  - CTRL and STATUS bit indices.
  - The default slot map constants.
- One sub-module: mio_timer. Owns COUNT/EN-clear logic and tick generation. Inputs are enable, period, period_wr and oneshot; outputs are count and a tick pulse.
- Decode, register file and read mux stay in the top level.

Test Plan:
- Decode: slot0 base 0 mask FFFF_F800, slot1 base 0x800 mask FFFF_F800. Read 0x804 → slot_sel=0b10, d_f_mem=slot_rd[63:32]. Read 0x2000 → slot_sel=0, d_f_mem=0. Overlap with slot0 and slot1 both matching 0x10 → slot0 selected.
- Timer: PERIOD=3, CTRL=0x3 → TICK rises 4 cycles after EN, then every 4 cycles; irq=1. W1C 0x1 on STATUS → irq=0 until the next tick. Clear coinciding with a tick → TICK remains 1.
- Oneshot: PERIOD=5, CTRL=0x7 → exactly one tick after 6 cycles, then CTRL reads 0x6 and COUNT holds 0. PERIOD=0 with EN=1 → COUNT never changes.
- Scratch/local: write 0x1010←0xDEAD_BEEF → reads back. Write to COUNT is ignored. Write to PERIOD mid-count → COUNT reads 0 next cycle. Byte address 0x1013 aliases SCRATCH0.
- Reset: assert rst_n=0 mid-count with TICK=1 → immediately COUNT=0, STATUS=0, irq=0, PERIOD=4_000_000.
- BUSERR (macro defined): write to 0x2000 then 0x3000 → ERR=1, ERRADDR=0x2000, irq only when EIE=1. Macro undefined → ERRADDR reads 0 and ERR never sets.
